// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: data width, NOP encoding and the {pc, instr} entry
// that travels from the memory response into the fetch buffer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/grant + in-order response bus.
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    import fetch_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

endinterface

// File: rtl/if_fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop/clear and an
// occupancy count; clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             push_i,
    input  fetch_entry_t                     entry_i,
    input  logic                             pop_i,
    output fetch_entry_t                     head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable gets its default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values. The storage is reset as well: downstream sees zeros on
    // pc/instr while reset is held rather than whatever was left over.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, response buffer, redirect flush.
// Define FETCH_BYPASS_EN to present a response on valid_o in its arrival cycle when the buffer is empty.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    if_fetch_stage_if.master imem,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             gnt_fire, rsp_fire, rsp_live, bypass;
    logic             fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, rsp_entry;

    // A response with nothing outstanding is a leftover from before a reset and is ignored.
    assign rsp_fire = imem.imem_rvalid_i && (outstanding_q != '0);
    assign rsp_live = rsp_fire && (discard_q == '0) && !redirect_i;
    assign gnt_fire = imem.imem_req_o && imem.imem_gnt_i;

    // In-flight plus buffered never exceeds the buffer depth, so a push always has room.
    assign imem.imem_req_o  = !rst_i && !redirect_i &&
                              (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem.imem_addr_o = pc_q;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && rsp_live;
`else
    assign bypass = 1'b0;
`endif

    assign rsp_entry = '{pc: rsp_pc_q, instr: imem.imem_rdata_i};
    assign valid_o   = !fifo_empty || bypass;
    assign pc_o      = bypass ? rsp_pc_q : fifo_head.pc;
    assign instr_o   = bypass ? imem.imem_rdata_i : fifo_head.instr;
    assign fifo_pop  = !fifo_empty && ready_i;
    assign fifo_push = rsp_live && !(bypass && ready_i);

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);
        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = word_align(redirect_pc_i);
            rsp_pc_d  = word_align(redirect_pc_i);
            discard_d = outstanding_q - CNT_W'(rsp_fire);
        end else begin
            if (gnt_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (fifo_push),
        .entry_i (rsp_entry),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Stray responses are legal after a mid-stream reset, so they are covered rather than asserted.
    cover property (@(posedge clk_i) disable iff (rst_i) imem.imem_rvalid_i && (outstanding_q == '0));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: queue-based reference model checked every cycle,
// plus literal expectations for ordering, redirect, wrap and reset scenarios.
module tb_if_fetch_stage;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o, ready_i;
    logic [31:0] instr_o, pc_o;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem          (bus.master),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Stimulus knobs, applied just after each rising edge.
    bit          rst_v, gnt_en, rv_en, rdy, redir, stray;
    logic [31:0] redir_pc;
    int          lat;
    int          cyc;

    typedef struct { logic [31:0] addr; int t; } mem_req_t;
    typedef struct { logic [31:0] addr; bit stale; } inflight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

    mem_req_t    mem_q[$];
    inflight_t   m_infl[$];
    entry_t      m_buf[$];
    logic [31:0] m_pc;
    logic [31:0] out_log[$];
    logic [31:0] iss_log[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] out_at(input int i);
        if (i < out_log.size()) return out_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        if (i < iss_log.size()) return iss_log[i];
        return 'x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: in-flight requests tagged stale on redirect, buffer as a queue.
    task automatic model_step();
        int          n_infl;
        bit          exp_req, has_rsp, live, byp, exp_valid;
        logic [31:0] exp_pc, exp_instr;
        inflight_t   r;
        n_infl  = m_infl.size();
        exp_req = !redirect_i && (n_infl + m_buf.size() < DEPTH);
        has_rsp = bus.imem_rvalid_i && (n_infl > 0);
        live    = has_rsp && !m_infl[0].stale && !redirect_i;
        byp     = BYP && (m_buf.size() == 0) && live;
        exp_valid = (m_buf.size() > 0) || byp;
        exp_pc    = byp ? m_infl[0].addr : (m_buf.size() > 0 ? m_buf[0].pc : 32'h0);
        exp_instr = byp ? word_of(m_infl[0].addr) : (m_buf.size() > 0 ? m_buf[0].instr : 32'h0);

        check("req", bus.imem_req_o, exp_req);
        if (exp_req) check("addr", bus.imem_addr_o, m_pc);
        check("valid", valid_o, exp_valid);
        if (exp_valid) begin
            check("pc", pc_o, exp_pc);
            check("instr", instr_o, exp_instr);
        end

        if (redirect_i) begin
            if (has_rsp) void'(m_infl.pop_front());
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_buf.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (exp_valid && ready_i && !byp) void'(m_buf.pop_front());
            if (has_rsp) begin
                r = m_infl.pop_front();
                if (!r.stale && !(byp && ready_i))
                    m_buf.push_back('{pc: r.addr, instr: word_of(r.addr)});
            end
            if (exp_req && gnt_en) begin
                m_infl.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        rst_i          = rst_v;
        ready_i        = rdy;
        redirect_i     = redir;
        redirect_pc_i  = redir_pc;
        bus.imem_gnt_i = gnt_en;
        if (rst_v) mem_q.delete();
        if (stray) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (rv_en && mem_q.size() > 0 && (cyc - mem_q[0].t) >= lat) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = word_of(mem_q[0].addr);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
        end
        @(negedge clk_i);
        if (rst_i) begin
            check("rst_req", bus.imem_req_o, 1'b0);
            check("rst_valid", valid_o, 1'b0);
            check("rst_pc", pc_o, 32'h0);
            check("rst_instr", instr_o, 32'h0);
            m_pc = RST_PC;
            m_infl.delete();
            m_buf.delete();
        end else begin
            model_step();
            if (bus.imem_rvalid_i && !stray) void'(mem_q.pop_front());
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                mem_q.push_back('{addr: bus.imem_addr_o, t: cyc});
                iss_log.push_back(bus.imem_addr_o);
            end
            if (valid_o && ready_i) out_log.push_back(pc_o);
        end
        cyc++;
    endtask

    task automatic drain();
        gnt_en = 1'b0; rv_en = 1'b1; rdy = 1'b1; redir = 1'b0; lat = 1;
        repeat (8) cycle();
    endtask

    logic [31:0] last_pc;

    initial begin
        rst_i = 1'b1; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        rst_v = 1'b1; gnt_en = 1'b0; rv_en = 1'b0; rdy = 1'b0; redir = 1'b0;
        stray = 1'b0; redir_pc = '0; lat = 1; cyc = 0;
        repeat (3) cycle();

        // Streaming fetch, one-cycle memory.
        rst_v = 1'b0; out_log.delete(); iss_log.delete();
        gnt_en = 1'b1; rv_en = 1'b1; rdy = 1'b1; lat = 1;
        repeat (12) cycle();
        check("t1_pc0", out_at(0), 32'h0);
        check("t1_pc1", out_at(1), 32'h4);
        check("t1_pc2", out_at(2), 32'h8);
        check("t1_pc3", out_at(3), 32'hC);

        // Downstream stall fills the buffer and throttles requests.
        last_pc = out_log[$];
        rdy = 1'b0;
        repeat (5) cycle();
        check("t2_req_throttled", bus.imem_req_o, 1'b0);
        check("t2_valid_held", valid_o, 1'b1);
        rdy = 1'b1; out_log.delete();
        repeat (10) cycle();
        check("t2_resumed", 32'(out_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("t2_in_order", out_at(i), last_pc + 32'(4 * (i + 1)));

        // Redirect with two requests in flight.
        drain();
        iss_log.delete();
        rv_en = 1'b0; gnt_en = 1'b1;
        repeat (2) cycle();
        check("t3_two_issued", 32'(iss_log.size()), 32'd2);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        cycle();
        check("t3_no_req_on_redirect", bus.imem_req_o, 1'b0);
        redir = 1'b0; out_log.delete(); rv_en = 1'b1;
        repeat (10) cycle();
        check("t3_first_pc", out_at(0), 32'h0000_0100);
        check("t3_second_pc", out_at(1), 32'h0000_0104);

        // Redirect coinciding with the only outstanding response.
        drain();
        rv_en = 1'b0; gnt_en = 1'b1;
        cycle();
        gnt_en = 1'b0; rv_en = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0200;
        cycle();
        redir = 1'b0; gnt_en = 1'b1; out_log.delete();
        cycle();
        check("t4_req_after", bus.imem_req_o, 1'b1);
        check("t4_addr_after", bus.imem_addr_o, 32'h0000_0200);
        repeat (8) cycle();
        check("t4_first_pc", out_at(0), 32'h0000_0200);

        // Two consecutive redirects, each with a response arriving.
        drain();
        rv_en = 1'b0; gnt_en = 1'b1;
        repeat (2) cycle();
        gnt_en = 1'b0; rv_en = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0300;
        cycle();
        redir_pc = 32'h0000_0400;
        cycle();
        redir = 1'b0; gnt_en = 1'b1; out_log.delete();
        cycle();
        check("t4b_addr_after", bus.imem_addr_o, 32'h0000_0400);
        repeat (8) cycle();
        check("t4b_first_pc", out_at(0), 32'h0000_0400);
        check("t4b_second_pc", out_at(1), 32'h0000_0404);

        // PC wrap at the top of the address space.
        drain();
        iss_log.delete(); out_log.delete();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        cycle();
        redir = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
        repeat (8) cycle();
        check("t5_iss0", iss_at(0), 32'hFFFF_FFFC);
        check("t5_iss1_wrapped", iss_at(1), 32'h0000_0000);
        check("t5_out0", out_at(0), 32'hFFFF_FFFC);
        check("t5_out1", out_at(1), 32'h0000_0000);

        // Mid-stream reset with two outstanding, then a stray response.
        drain();
        rv_en = 1'b0; gnt_en = 1'b1;
        repeat (2) cycle();
        rst_v = 1'b1;
        repeat (2) cycle();
        rst_v = 1'b0; stray = 1'b1; gnt_en = 1'b0; iss_log.delete(); out_log.delete();
        cycle();
        stray = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
        repeat (8) cycle();
        check("t6_restart_addr", iss_at(0), RST_PC);
        check("t6_out0", out_at(0), RST_PC);
        check("t6_out1", out_at(1), RST_PC + 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
